key_debounce_scan: RTL

//  Input-side counterpart to the LED output driver in the key_lcd_seg project.

---
 rtl/key_debounce_scan_pkg.sv | 24 ++
 rtl/key_debounce_ch.sv | 138 +++++++++++++
 rtl/key_debounce_scan.sv | 50 +++++
 3 files changed

// File: rtl/key_debounce_scan_pkg.sv
// rtl/key_debounce_scan_pkg.sv - shared state encodings, default timing and counter sizing for key debounce
package key_debounce_scan_pkg;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PRESS_DEB = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_REL_DEB   = 2'd3;

    // Defaults for a 50 MHz clock: 20 ms debounce, 0.5 s hold, 0.1 s repeat
    localparam int DEF_KEY_W         = 4;
    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_HOLD_CYCLES   = 25000000;
    localparam int DEF_REPEAT_CYCLES = 5000000;
    localparam int DEF_REPEAT_EN     = 1;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key: 2-flop synchroniser, debounce FSM, hold/auto-repeat timer
module key_debounce_ch
    import key_debounce_scan_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN,
    parameter int CNT_W         = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)
)(
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic rpt,
    output logic press_nxt
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic             RPT_ON    = (REPEAT_EN != 0);

    logic             sync_a;
    logic             key_s;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             rep_phase, rep_nxt;
    logic             level_nxt, rel_nxt, rpt_nxt;

    // Synchroniser idles at 1 (released) so leaving reset never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            key_s  <= 1'b1;
        end else begin
            sync_a <= key_n;
            key_s  <= sync_a;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        rep_nxt   = rep_phase;
        level_nxt = level;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        rpt_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!key_s) begin
                    state_nxt = S_PRESS_DEB;
                    deb_nxt   = '0;
                end
            end
            S_PRESS_DEB: begin
                if (key_s) begin
                    state_nxt = S_IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt = S_HELD;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                    rep_nxt   = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (key_s) begin
                    state_nxt = S_REL_DEB;
                    deb_nxt   = '0;
                end else if (hold_cnt >= (rep_phase ? REP_LAST : HOLD_LAST)) begin
                    // Without repeat the timer simply parks at its limit
                    if (RPT_ON) begin
                        rpt_nxt  = 1'b1;
                        hold_nxt = '0;
                        rep_nxt  = 1'b1;
                    end
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            S_REL_DEB: begin
                if (!key_s) begin
                    state_nxt = S_HELD;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                    rep_nxt   = 1'b0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt = S_IDLE;
                    rel_nxt   = 1'b1;
                    level_nxt = 1'b0;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
                rep_nxt   = 1'b0;
                level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            rep_phase <= 1'b0;
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            rpt       <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            rep_phase <= rep_nxt;
            level     <= level_nxt;
            press     <= press_nxt;
            rel       <= rel_nxt;
            rpt       <= rpt_nxt;
        end
    end

endmodule

// File: rtl/key_debounce_scan.sv
// rtl/key_debounce_scan.sv - KEY_W independent debounced keys with press/release/repeat pulses
module key_debounce_scan
    import key_debounce_scan_pkg::*;
#(
    parameter int KEY_W         = DEF_KEY_W,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = DEF_REPEAT_EN
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_n,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_rpt,
    output logic             key_any
);

    localparam int CNT_W = cnt_width(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    logic [KEY_W-1:0] press_nxt;

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_debounce_ch #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .CNT_W         (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .key_n     (key_n[g]),
            .level     (key_level[g]),
            .press     (key_press[g]),
            .rel       (key_release[g]),
            .rpt       (key_rpt[g]),
            .press_nxt (press_nxt[g])
        );
    end

    // Registered from the channels' next-press terms so it lines up with key_press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_any <= 1'b0;
        else     key_any <= |press_nxt;
    end

endmodule
